match_position_collector: RTL and testbench

- Downstream stage of the parallel sequence detector. Consumes the per-cycle match bitmask (one bit per bit position of the input word) and converts every set bit into an absolute stream bit offset.
- Offsets are emitted one per cycle over a valid/ready handshake.
- Bursty masks are absorbed in a small word FIFO. Overflow is flagged, never back-pressured upstream, because the detector cannot stall.

---
 rtl/psd_pkg.sv | 28 ++
 rtl/mpc_word_fifo.sv | 57 +++++
 rtl/match_position_collector.sv | 161 ++++++++++++++++
 tb/tb_match_position_collector.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/psd_pkg.sv
// Shared definitions for the parallel sequence detector: default widths,
// a constant-evaluable clog2 and the match extractor state encoding.
package psd_pkg;

    localparam int WID_BITSTREAM_DEF = 32;

    typedef enum logic {
        EXT_Idle = 1'b0,
        EXT_Emit = 1'b1
    } ext_state_t;

    // Smallest n with 2**n >= value; usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int f_offset_width(input int wid_wordcount, input int wid_bitstream);
        return wid_wordcount + clog2(wid_bitstream);
    endfunction

endpackage

// File: rtl/mpc_word_fifo.sv
// Synchronous FIFO holding {mask, word index} entries. Read data comes from the
// registered head, so a word pushed into an empty FIFO is visible one cycle later.
module mpc_word_fifo
    import psd_pkg::*;
#(
    parameter int WID_Data = 8,
    parameter int DEPTH    = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_clear,
    input  logic                i_push,
    input  logic [WID_Data-1:0] i_data,
    input  logic                i_pop,
    output logic [WID_Data-1:0] o_data,
    output logic                o_full,
    output logic                o_empty
);

    localparam int WID_Ptr = clog2(DEPTH);

    logic [WID_Data-1:0] r_mem [DEPTH];
    logic [WID_Ptr:0]    r_wr_ptr;
    logic [WID_Ptr:0]    r_rd_ptr;
    logic                w_push;
    logic                w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[WID_Ptr] != r_rd_ptr[WID_Ptr]) &&
                     (r_wr_ptr[WID_Ptr-1:0] == r_rd_ptr[WID_Ptr-1:0]);
    assign o_data  = r_mem[r_rd_ptr[WID_Ptr-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (WID_Ptr+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (WID_Ptr+1)'(1);
            end
        end
    end

    // Storage write.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[WID_Ptr-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/match_position_collector.sv
// Turns per-word match masks into absolute bit offsets {word_index, bit},
// emitted lowest bit first over valid/ready; bursts are buffered, excess flagged.
module match_position_collector
    import psd_pkg::*;
#(
    parameter int  WID_Bitstream = WID_BITSTREAM_DEF,
    parameter int  WID_WordCount = 16,
    parameter int  DEPTH_Fifo    = 16,
    localparam int WID_Offset    = f_offset_width(WID_WordCount, WID_Bitstream)
) (
    input  logic                     local_MPC_clk,
    input  logic                     local_MPC_reset,
    input  logic                     local_MPC_newstream,
    input  logic                     local_MPC_valid,
    input  logic [WID_Bitstream-1:0] local_MPC_position,
    output logic                     MPC_local_valid,
    input  logic                     local_MPC_ready,
    output logic [WID_Offset-1:0]    MPC_local_offset,
    output logic                     MPC_local_busy,
    output logic                     MPC_local_overflow,
    output logic [WID_Offset-1:0]    MPC_local_count
);

    localparam int WID_Sel   = clog2(WID_Bitstream);
    localparam int WID_Entry = WID_Bitstream + WID_WordCount;

    function automatic logic [WID_Sel-1:0] f_lowest_set(input logic [WID_Bitstream-1:0] mask);
        logic [WID_Sel-1:0] pos;
        pos = '0;
        for (int i = WID_Bitstream - 1; i >= 0; i--) begin
            if (mask[i]) begin
                pos = WID_Sel'(i);
            end
        end
        return pos;
    endfunction

    logic [WID_WordCount-1:0] r_index;
    logic                     r_overflow;
    logic [WID_Offset-1:0]    r_count;
    ext_state_t               r_state;
    logic [WID_Bitstream-1:0] r_mask;
    logic [WID_WordCount-1:0] r_word_idx;

    ext_state_t               w_state_nxt;
    logic [WID_Bitstream-1:0] w_mask_nxt;
    logic [WID_WordCount-1:0] w_idx_nxt;
    logic                     w_pop;
    logic                     w_accept;
    logic                     w_nonzero;
    logic                     w_push;
    logic                     w_drop;
    logic                     w_handshake;
    logic [WID_Bitstream-1:0] w_mask_rest;
    logic [WID_Entry-1:0]     w_fifo_data;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;

    assign w_accept    = local_MPC_valid & ~local_MPC_newstream;
    assign w_nonzero   = |local_MPC_position;
    assign w_push      = w_accept & w_nonzero & ~w_fifo_full;
    assign w_drop      = w_accept & w_nonzero & w_fifo_full;
    assign w_handshake = (r_state == EXT_Emit) & local_MPC_ready;
    // Clearing the lowest set bit: m & (m - 1).
    assign w_mask_rest = r_mask & (r_mask - WID_Bitstream'(1));

    assign MPC_local_valid    = (r_state == EXT_Emit);
    assign MPC_local_offset   = {r_word_idx, f_lowest_set(r_mask)};
    assign MPC_local_busy     = ~w_fifo_empty | (r_state == EXT_Emit);
    assign MPC_local_overflow = r_overflow;
    assign MPC_local_count    = r_count;

    mpc_word_fifo #(
        .WID_Data (WID_Entry),
        .DEPTH    (DEPTH_Fifo)
    ) u_fifo (
        .i_clk   (local_MPC_clk),
        .i_reset (local_MPC_reset),
        .i_clear (local_MPC_newstream),
        .i_push  (w_push),
        .i_data  ({local_MPC_position, r_index}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Stream bookkeeping: word index, sticky overflow, saturating match count.
    always_ff @(posedge local_MPC_clk) begin
        if (local_MPC_reset || local_MPC_newstream) begin
            r_index    <= '0;
            r_overflow <= 1'b0;
            r_count    <= '0;
        end else begin
            if (w_accept) begin
                r_index <= r_index + WID_WordCount'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_handshake && (r_count != {WID_Offset{1'b1}})) begin
                r_count <= r_count + WID_Offset'(1);
            end
        end
    end

    // Extractor state and working mask registers.
    always_ff @(posedge local_MPC_clk) begin
        if (local_MPC_reset || local_MPC_newstream) begin
            r_state    <= EXT_Idle;
            r_mask     <= '0;
            r_word_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mask     <= w_mask_nxt;
            r_word_idx <= w_idx_nxt;
        end
    end

    // Extractor next state; the last bit of a mask reloads from the FIFO without a bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_idx_nxt   = r_word_idx;
        w_pop       = 1'b0;
        case (r_state)
            EXT_Idle: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_mask_nxt  = w_fifo_data[WID_Entry-1:WID_WordCount];
                    w_idx_nxt   = w_fifo_data[WID_WordCount-1:0];
                    w_state_nxt = EXT_Emit;
                end else begin
                    w_state_nxt = EXT_Idle;
                end
            end
            EXT_Emit: begin
                if (w_handshake) begin
                    w_mask_nxt = w_mask_rest;
                    if (w_mask_rest != '0) begin
                        w_state_nxt = EXT_Emit;
                    end else if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_mask_nxt  = w_fifo_data[WID_Entry-1:WID_WordCount];
                        w_idx_nxt   = w_fifo_data[WID_WordCount-1:0];
                        w_state_nxt = EXT_Emit;
                    end else begin
                        w_state_nxt = EXT_Idle;
                    end
                end else begin
                    w_state_nxt = EXT_Emit;
                end
            end
            default: begin
                w_state_nxt = EXT_Idle;
                w_mask_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_match_position_collector.sv
// Directed bench for match_position_collector (8-bit masks, 4-bit index, 4-deep FIFO):
// expected offsets queued at stimulus time, popped by a handshake monitor.
module tb_match_position_collector;

    localparam int WB = 8;
    localparam int WW = 4;
    localparam int DF = 4;
    localparam int WO = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          newstream;
    logic          valid;
    logic [WB-1:0] position;
    logic          ready;
    logic          o_valid;
    logic [WO-1:0] o_offset;
    logic          o_busy;
    logic          o_overflow;
    logic [WO-1:0] o_count;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int mon_exp;

    match_position_collector #(
        .WID_Bitstream (WB),
        .WID_WordCount (WW),
        .DEPTH_Fifo    (DF)
    ) dut (
        .local_MPC_clk       (clk),
        .local_MPC_reset     (reset),
        .local_MPC_newstream (newstream),
        .local_MPC_valid     (valid),
        .local_MPC_position  (position),
        .MPC_local_valid     (o_valid),
        .local_MPC_ready     (ready),
        .MPC_local_offset    (o_offset),
        .MPC_local_busy      (o_busy),
        .MPC_local_overflow  (o_overflow),
        .MPC_local_count     (o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [WB-1:0] m);
        valid    = 1'b1;
        position = m;
        tick();
        valid    = 1'b0;
        position = '0;
    endtask

    task automatic push_exp(input logic [WB-1:0] m, input int idx);
        for (int b = 0; b < WB; b++) begin
            if (m[b]) exp_q.push_back(idx * WB + b);
        end
    endtask

    task automatic ns();
        newstream = 1'b1;
        tick();
        newstream = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: every accepted offset must match the head of the expected queue.
    always @(negedge clk) begin
        if (o_valid === 1'b1 && ready === 1'b1 && reset === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_offset: got %0d, expected none", o_offset);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("offset", int'(o_offset), mon_exp);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        newstream = 1'b0;
        valid     = 1'b0;
        position  = '0;
        ready     = 1'b0;
        tick();
        tick();
        chk("reset_valid", o_valid, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_count", o_count, 0);
        chk("reset_overflow", o_overflow, 0);
        reset = 1'b0;

        // 1: latency and back-to-back offsets
        ns();
        ready = 1'b1;
        word(8'h00);
        push_exp(8'h05, 1);
        word(8'h05);
        chk("s1_valid_n1", o_valid, 0);
        tick();
        chk("s1_valid_n2", o_valid, 1);
        chk("s1_first_off", o_offset, 8);
        tick();
        chk("s1_second_valid", o_valid, 1);
        chk("s1_second_off", o_offset, 10);
        tick();
        chk("s1_valid_end", o_valid, 0);
        chk("s1_count", o_count, 2);
        chk("s1_busy", o_busy, 0);
        chk("s1_queue", exp_q.size(), 0);

        // 2: hold under back-pressure
        ns();
        ready = 1'b0;
        word(8'h00);
        push_exp(8'h05, 1);
        word(8'h05);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("s2_hold_valid", o_valid, 1);
            chk("s2_hold_off", o_offset, 8);
            tick();
        end
        ready = 1'b1;
        tick();
        tick();
        chk("s2_count", o_count, 2);
        chk("s2_valid_end", o_valid, 0);
        chk("s2_busy", o_busy, 0);
        chk("s2_queue", exp_q.size(), 0);

        // 3: burst, overflow on the word that finds the FIFO full, gapless drain
        ns();
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_exp(8'hFF, k);
            word(8'hFF);
        end
        chk("s3_overflow_before", o_overflow, 0);
        word(8'hFF);
        chk("s3_overflow_after", o_overflow, 1);
        chk("s3_busy", o_busy, 1);
        chk("s3_head_off", o_offset, 0);
        ready = 1'b1;
        repeat (40) tick();
        chk("s3_count", o_count, 40);
        chk("s3_valid_end", o_valid, 0);
        chk("s3_busy_end", o_busy, 0);
        chk("s3_overflow_sticky", o_overflow, 1);
        chk("s3_queue", exp_q.size(), 0);

        // 4: newstream mid-drain discards its own word and restarts the index
        ns();
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_exp(8'hFF, k);
            word(8'hFF);
        end
        word(8'hFF);
        ready = 1'b1;
        repeat (5) tick();
        newstream = 1'b1;
        valid     = 1'b1;
        position  = 8'h01;
        tick();
        newstream = 1'b0;
        valid     = 1'b0;
        position  = '0;
        exp_q.delete();
        chk("s4_valid", o_valid, 0);
        chk("s4_busy", o_busy, 0);
        chk("s4_count", o_count, 0);
        chk("s4_overflow", o_overflow, 0);
        push_exp(8'h02, 0);
        word(8'h02);
        tick();
        chk("s4_off", o_offset, 1);
        tick();
        chk("s4_count_end", o_count, 1);
        chk("s4_queue", exp_q.size(), 0);

        // 5: index wraps after 16 words
        ns();
        ready = 1'b1;
        repeat (16) word(8'h00);
        push_exp(8'h80, 0);
        word(8'h80);
        tick();
        chk("s5_valid", o_valid, 1);
        chk("s5_off", o_offset, 7);
        tick();
        tick();
        chk("s5_count", o_count, 1);
        chk("s5_queue", exp_q.size(), 0);

        // 6: synchronous reset mid-operation
        ns();
        ready = 1'b0;
        word(8'h03);
        word(8'h03);
        tick();
        chk("s6_busy_pre", o_busy, 1);
        reset    = 1'b1;
        valid    = 1'b1;
        position = 8'hFF;
        tick();
        chk("s6_valid", o_valid, 0);
        chk("s6_offset", o_offset, 0);
        chk("s6_busy", o_busy, 0);
        chk("s6_overflow", o_overflow, 0);
        chk("s6_count", o_count, 0);
        reset    = 1'b0;
        valid    = 1'b0;
        position = '0;
        ready    = 1'b1;
        repeat (6) tick();
        chk("s6_valid_end", o_valid, 0);
        chk("s6_busy_end", o_busy, 0);
        chk("s6_count_end", o_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
